// File: rtl/ftdi_pkg.sv
// Shared types and elaboration-time parameter checks for the FTDI 245-style FIFO bridge.
package ftdi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WR_LOW,
    ST_RD_LOW,
    ST_RECOVER
  } bus_st_e;

  localparam int ARB_RD_PRIO = 0;
  localparam int ARB_RR      = 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit cfg_ok(input int pkt, input int setup, input int wr_low,
                                input int rd_low, input int rd_sample, input int recover,
                                input int sync, input int arb);
    return (pkt >= 2) && (setup >= 1) && (wr_low >= 1) && (rd_low >= 2) &&
           (sync >= 1) && (sync < rd_sample) && (rd_sample <= rd_low) &&
           (recover >= 1) && ((arb == ARB_RD_PRIO) || (arb == ARB_RR));
  endfunction

endpackage

// File: rtl/ftdi_packetizer.sv
// One-byte hold register that frames the outbound stream into fixed-length packets,
// padding a short packet out to PKT_BYTES after tx_last.
module ftdi_packetizer
  import ftdi_pkg::*;
#(
  parameter int         PKT_BYTES = 1024,
  parameter logic [7:0] PAD_BYTE  = 8'h01,
  parameter int         PKT_W     = $clog2(PKT_BYTES + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  input  logic             tx_last,
  output logic             tx_ready,
  input  logic             pop,
  output logic             hold_full,
  output logic [7:0]       hold_data,
  output logic             pad_active,
  output logic [PKT_W-1:0] pkt_ct
);

  logic             full_q, pad_q;
  logic [7:0]       hold_q;
  logic [PKT_W-1:0] ct_q, ct_inc;
  logic             accept, pad_load, wrap;

  assign tx_ready   = !pad_q && !full_q;
  assign accept     = tx_valid && tx_ready;
  assign pad_load   = pad_q && !full_q;
  assign ct_inc     = ct_q + PKT_W'(1);
  assign wrap       = (ct_inc == PKT_W'(PKT_BYTES));

  assign hold_full  = full_q;
  assign hold_data  = hold_q;
  assign pad_active = pad_q;
  assign pkt_ct     = ct_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      pad_q  <= 1'b0;
      hold_q <= '0;
      ct_q   <= '0;
    end else if (clear) begin
      full_q <= 1'b0;
      pad_q  <= 1'b0;
      hold_q <= '0;
      ct_q   <= '0;
    end else if (accept || pad_load) begin
      full_q <= 1'b1;
      hold_q <= accept ? tx_data : PAD_BYTE;
      ct_q   <= wrap ? '0 : ct_inc;
      // The byte that completes the packet ends padding; tx_last on it needs none.
      if (wrap)                    pad_q <= 1'b0;
      else if (accept && tx_last)  pad_q <= 1'b1;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ftdi_fifo_bridge.sv
// Bridges valid/ready byte streams to FT245-style async FIFO pins with programmable
// setup/strobe/recovery timing and read-priority or round-robin arbitration.
module ftdi_fifo_bridge
  import ftdi_pkg::*;
#(
  parameter int         PKT_BYTES     = 1024,
  parameter logic [7:0] PAD_BYTE      = 8'h01,
  parameter int         SETUP_CYC     = 1,
  parameter int         WR_LOW_CYC    = 2,
  parameter int         RD_LOW_CYC    = 5,
  parameter int         RD_SAMPLE_CYC = 4,
  parameter int         RECOVER_CYC   = 2,
  parameter int         SYNC_STAGES   = 2,
  parameter int         ARB_MODE      = 0
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           clear,
  input  logic                           rd_en,
  input  logic                           wr_en,
  input  logic [7:0]                     tx_data,
  input  logic                           tx_valid,
  input  logic                           tx_last,
  output logic                           tx_ready,
  output logic [7:0]                     rx_data,
  output logic                           rx_valid,
  input  logic                           rx_ready,
  input  logic                           txe_n,
  input  logic                           rxf_n,
  input  logic [7:0]                     adbus_in,
  output logic [7:0]                     adbus_out,
  output logic                           adbus_oe,
  output logic                           ftdi_wr_n,
  output logic                           ftdi_rd_n,
  output logic                           pad_active,
  output logic [$clog2(PKT_BYTES+1)-1:0] pkt_ct
);

  localparam int MAX_PH = max2(max2(SETUP_CYC, WR_LOW_CYC), max2(RD_LOW_CYC, RECOVER_CYC));
  localparam int CNT_W  = $clog2(MAX_PH + 1);
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(RD_LOW_CYC - RD_SAMPLE_CYC);

  if (!cfg_ok(PKT_BYTES, SETUP_CYC, WR_LOW_CYC, RD_LOW_CYC, RD_SAMPLE_CYC,
              RECOVER_CYC, SYNC_STAGES, ARB_MODE)) begin : g_bad_cfg
    $error("ftdi_fifo_bridge: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0]      txe_sync_q, rxf_sync_q;
  logic [SYNC_STAGES-1:0][7:0] bus_sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      txe_sync_q <= '1;
      rxf_sync_q <= '1;
      bus_sync_q <= '0;
    end else begin
      txe_sync_q[0] <= txe_n;
      rxf_sync_q[0] <= rxf_n;
      bus_sync_q[0] <= adbus_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        txe_sync_q[i] <= txe_sync_q[i-1];
        rxf_sync_q[i] <= rxf_sync_q[i-1];
        bus_sync_q[i] <= bus_sync_q[i-1];
      end
    end
  end

  bus_st_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wr_next_q, wr_n_q, rd_n_q, oe_q, rx_valid_q;
  logic [7:0]       dout_q, rx_data_q;
  logic             hold_full, pop, rd_elig, wr_elig, grant_rd, grant_wr;
  logic [7:0]       hold_data;

  assign rd_elig  = rd_en && !rxf_sync_q[SYNC_STAGES-1] && !rx_valid_q;
  assign wr_elig  = wr_en && !txe_sync_q[SYNC_STAGES-1] && hold_full;
  // Round-robin only matters on contention; the pointer tracks whichever was granted last.
  assign grant_rd = (ARB_MODE == ARB_RD_PRIO) ? rd_elig
                                              : (rd_elig && (!wr_elig || !wr_next_q));
  assign grant_wr = wr_elig && !grant_rd;
  assign pop      = (state_q == ST_IDLE) && grant_wr && !clear;

  ftdi_packetizer #(
    .PKT_BYTES (PKT_BYTES),
    .PAD_BYTE  (PAD_BYTE),
    .PKT_W     ($clog2(PKT_BYTES+1))
  ) u_pkt (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .pop        (pop),
    .hold_full  (hold_full),
    .hold_data  (hold_data),
    .pad_active (pad_active),
    .pkt_ct     (pkt_ct)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_next_q  <= 1'b1;
      wr_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      dout_q     <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else if (clear) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_next_q  <= 1'b1;
      wr_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      dout_q     <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_rd) begin
            state_q   <= ST_RD_LOW;
            rd_n_q    <= 1'b0;
            cnt_q     <= CNT_W'(RD_LOW_CYC - 1);
            wr_next_q <= 1'b1;
          end else if (grant_wr) begin
            state_q   <= ST_SETUP;
            dout_q    <= hold_data;
            oe_q      <= 1'b1;
            cnt_q     <= CNT_W'(SETUP_CYC - 1);
            wr_next_q <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= ST_WR_LOW;
            wr_n_q  <= 1'b0;
            cnt_q   <= CNT_W'(WR_LOW_CYC - 1);
          end else cnt_q <= cnt_q - CNT_W'(1);
        end
        ST_WR_LOW: begin
          if (cnt_q == '0) begin
            state_q <= ST_RECOVER;
            wr_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            cnt_q   <= CNT_W'(RECOVER_CYC - 1);
          end else cnt_q <= cnt_q - CNT_W'(1);
        end
        ST_RD_LOW: begin
          // Counter runs RD_LOW_CYC-1 .. 0, so this is 1-based cycle RD_SAMPLE_CYC.
          if (cnt_q == SAMPLE_AT) begin
            rx_data_q  <= bus_sync_q[SYNC_STAGES-1];
            rx_valid_q <= 1'b1;
          end
          if (cnt_q == '0) begin
            state_q <= ST_RECOVER;
            rd_n_q  <= 1'b1;
            cnt_q   <= CNT_W'(RECOVER_CYC - 1);
          end else cnt_q <= cnt_q - CNT_W'(1);
        end
        ST_RECOVER: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign adbus_out = dout_q;
  assign adbus_oe  = oe_q;
  assign ftdi_wr_n = wr_n_q;
  assign ftdi_rd_n = rd_n_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;

endmodule

// File: tb/tb_ftdi_fifo_bridge.sv
// Directed bench: dut0 is read-priority, dut1 round-robin; both use PKT_BYTES=8 and default timing.
module tb_ftdi_fifo_bridge;

  logic       clock = 1'b0, reset_n = 1'b0, clear = 1'b0;
  logic       rd_en = 1'b0, wr_en = 1'b0, tx_valid = 1'b0, tx_last = 1'b0, rx_ready = 1'b0;
  logic       txe_n = 1'b1, rxf_n = 1'b1;
  logic [7:0] tx_data = '0, adbus_in = '0;

  logic       tx_ready0, rx_valid0, oe0, wr_n0, rd_n0, pad0;
  logic [7:0] rx_data0, dout0;
  logic [3:0] pkt_ct0;
  logic       tx_ready1, rx_valid1, oe1, wr_n1, rd_n1, pad1;
  logic [7:0] rx_data1, dout1;
  logic [3:0] pkt_ct1;

  always #5 clock = ~clock;

  ftdi_fifo_bridge #(.PKT_BYTES(8), .ARB_MODE(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .rd_en(rd_en), .wr_en(wr_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready),
    .txe_n(txe_n), .rxf_n(rxf_n), .adbus_in(adbus_in), .adbus_out(dout0), .adbus_oe(oe0),
    .ftdi_wr_n(wr_n0), .ftdi_rd_n(rd_n0), .pad_active(pad0), .pkt_ct(pkt_ct0));

  ftdi_fifo_bridge #(.PKT_BYTES(8), .ARB_MODE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .rd_en(rd_en), .wr_en(wr_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready),
    .txe_n(txe_n), .rxf_n(rxf_n), .adbus_in(adbus_in), .adbus_out(dout1), .adbus_oe(oe1),
    .ftdi_wr_n(wr_n1), .ftdi_rd_n(rd_n1), .pad_active(pad1), .pkt_ct(pkt_ct1));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Strobe monitor: bytes on each wr_n fall, and a grant log (1=write, 0=read) per instance.
  logic [7:0] wq0[$];
  bit         seq0[$], seq1[$];
  bit         pw0 = 1, pr0 = 1, pw1 = 1, pr1 = 1, pad_seen0 = 0;
  int         rd_falls0 = 0;

  always @(negedge clock) begin
    if (pw0 && !wr_n0) begin wq0.push_back(dout0); seq0.push_back(1'b1); end
    if (pr0 && !rd_n0) begin rd_falls0++; seq0.push_back(1'b0); end
    if (pw1 && !wr_n1) seq1.push_back(1'b1);
    if (pr1 && !rd_n1) seq1.push_back(1'b0);
    if (pad0) pad_seen0 = 1;
    pw0 = wr_n0; pr0 = rd_n0; pw1 = wr_n1; pr1 = rd_n1;
  end

  task automatic send(input logic [7:0] d, input logic last);
    bit ok = 0;
    @(negedge clock);
    tx_data = d; tx_last = last; tx_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (tx_ready0) begin ok = 1; break; end
      @(negedge clock);
    end
    chk("tx_accept", 32'(ok), 32'd1);
    @(posedge clock); #1;
    tx_valid = 1'b0; tx_last = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < 2000 && wq0.size() < n; i++) @(negedge clock);
    repeat (20) @(negedge clock);
    chk("wr_count", 32'(wq0.size()), 32'(n));
  endtask

  task automatic wait_rx_valid0();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (rx_valid0) begin ok = 1; break; end
    end
    chk("rx_valid_wait", 32'(ok), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_a[8] = '{8'hA1, 8'hB2, 8'hC3, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    int oe_cyc, wrl_cyc, gap, phase, nrd, nwr, viol, f0;

    repeat (3) @(negedge clock);
    chk("rst_wr_n", 32'(wr_n0), 32'd1);
    chk("rst_rd_n", 32'(rd_n0), 32'd1);
    chk("rst_oe", 32'(oe0), 32'd0);
    chk("rst_dout", 32'(dout0), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid0), 32'd0);
    chk("rst_pkt_ct", 32'(pkt_ct0), 32'd0);
    chk("rst_pad", 32'(pad0), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready0), 32'd1);
    reset_n = 1'b1;
    wr_en = 1'b1; txe_n = 1'b0;
    repeat (5) @(negedge clock);

    // Short packet: A,B,C then five pad bytes.
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hC3, 1'b1);
    chk("pad_ct_after_last", 32'(pkt_ct0), 32'd3);
    chk("pad_active_after_last", 32'(pad0), 32'd1);
    wait_writes(8);
    for (int i = 0; i < 8; i++) chk($sformatf("pad_byte%0d", i), 32'(wq0[i]), 32'(exp_a[i]));
    chk("pad_ct_wrap", 32'(pkt_ct0), 32'd0);
    chk("pad_done", 32'(pad0), 32'd0);

    // Full packet with tx_last on the final byte: no padding.
    wq0.delete(); pad_seen0 = 0;
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), i == 7);
    chk("full_ct_wrap", 32'(pkt_ct0), 32'd0);
    wait_writes(8);
    for (int i = 0; i < 8; i++) chk($sformatf("full_byte%0d", i), 32'(wq0[i]), 32'h10 + i);
    chk("full_no_pad", 32'(pad_seen0), 32'd0);

    // Two back-to-back writes: oe 3+3 cycles, wr_n low 2+2, wr_n high 4 between strobes.
    oe_cyc = 0; wrl_cyc = 0; gap = 0; phase = 0;
    fork
      begin
        repeat (40) begin
          @(negedge clock);
          if (oe0) oe_cyc++;
          if (!wr_n0) begin
            wrl_cyc++;
            if (phase == 0) phase = 1;
            if (phase == 2) phase = 3;
          end else begin
            if (phase == 1) phase = 2;
            if (phase == 2) gap++;
          end
        end
      end
      begin
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
      end
    join
    chk("tm_oe_cycles", 32'(oe_cyc), 32'd6);
    chk("tm_wr_low_cycles", 32'(wrl_cyc), 32'd4);
    chk("tm_strobe_gap", 32'(gap), 32'd4);
    chk("tm_pkt_ct", 32'(pkt_ct0), 32'd2);

    // Arbitration with both sides permanently eligible.
    @(posedge clock); #1;
    wr_en = 1'b0; rd_en = 1'b1; rxf_n = 1'b0; rx_ready = 1'b1; adbus_in = 8'h5A;
    seq0.delete(); seq1.delete();
    repeat (4) @(negedge clock);
    wr_en = 1'b1; tx_valid = 1'b1; tx_data = 8'h99;
    repeat (160) @(negedge clock);
    rd_en = 1'b0; wr_en = 1'b0; tx_valid = 1'b0; rxf_n = 1'b1;
    repeat (20) @(negedge clock);
    nrd = 0; nwr = 0;
    foreach (seq0[i]) if (seq0[i]) nwr++; else nrd++;
    chk("arb0_no_writes", 32'(nwr), 32'd0);
    chk("arb0_reads_repeat", 32'(nrd >= 15), 32'd1);
    chk("arb0_rx_data", 32'(rx_data0), 32'h5A);
    viol = 0;
    for (int i = 1; i < seq1.size(); i++) if (seq1[i] == seq1[i-1]) viol++;
    chk("arb1_alternate", 32'(viol), 32'd0);
    chk("arb1_enough", 32'(seq1.size() >= 10), 32'd1);

    // Back-pressure: one read, then rd_n stays high and rx_data holds.
    rx_ready = 1'b0; adbus_in = 8'h3C; rd_en = 1'b1; rxf_n = 1'b0;
    wait_rx_valid0();
    chk("bp_first_data", 32'(rx_data0), 32'h3C);
    f0 = rd_falls0;
    adbus_in = 8'hC3;
    repeat (30) @(negedge clock);
    chk("bp_no_more_reads", 32'(rd_falls0 - f0), 32'd0);
    chk("bp_rd_n_high", 32'(rd_n0), 32'd1);
    chk("bp_data_stable", 32'(rx_data0), 32'h3C);
    chk("bp_valid_held", 32'(rx_valid0), 32'd1);
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
    chk("bp_consumed", 32'(rx_valid0), 32'd0);
    wait_rx_valid0();
    chk("bp_second_data", 32'(rx_data0), 32'hC3);

    // Clear during RD_LOW cycle 2.
    @(negedge clock);
    rx_ready = 1'b1;
    begin
      bit ok = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clock);
        if (!rd_n0) begin ok = 1; break; end
      end
      chk("clr_read_started", 32'(ok), 32'd1);
    end
    @(negedge clock);
    chk("clr_in_rd_low", 32'(rd_n0), 32'd0);
    clear = 1'b1; tx_valid = 1'b1; tx_data = 8'hEE;
    @(negedge clock);
    chk("clr_rd_n", 32'(rd_n0), 32'd1);
    chk("clr_oe", 32'(oe0), 32'd0);
    chk("clr_rx_valid", 32'(rx_valid0), 32'd0);
    chk("clr_rx_data", 32'(rx_data0), 32'd0);
    chk("clr_pkt_ct", 32'(pkt_ct0), 32'd0);
    @(negedge clock);
    chk("clr_beats_handshake", 32'(pkt_ct0), 32'd0);
    clear = 1'b0; tx_valid = 1'b0; rd_en = 1'b0; rxf_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("clr_capture_discarded", 32'(rx_valid0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
